// File: rtl/pattern_pkg.sv
// Shared types and defaults for the pattern FIFO drain path.
package pattern_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_WAIT,
    S_SHIFT,
    S_DONE
  } state_t;

  localparam int unsigned DEF_DATA_W        = 256;
  localparam int unsigned DEF_OUT_W         = 32;
  localparam int unsigned DEF_WORDS_PER_PAT = 640;
  localparam int unsigned DEF_CNT_W         = 32;
  localparam int unsigned BEATS             = DEF_DATA_W / DEF_OUT_W;

  function automatic int unsigned beats_of(input int unsigned data_w, input int unsigned out_w);
    return data_w / out_w;
  endfunction

endpackage

// File: rtl/pattern_word_ser.sv
// Holds one FIFO word and steps it out LSB lane first, one beat per valid/ready handshake.
module pattern_word_ser
  import pattern_pkg::*;
#(
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned OUT_W  = DEF_OUT_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [DATA_W-1:0] word,
  input  logic              ready,
  output logic [OUT_W-1:0]  data,
  output logic              valid,
  output logic              last_beat,
  output logic              word_done
);

  localparam int unsigned NBEATS = beats_of(DATA_W, OUT_W);
  localparam int unsigned BEAT_W = (NBEATS > 1) ? $clog2(NBEATS) : 1;
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(NBEATS - 1);

  logic [DATA_W-1:0] word_q;
  logic [BEAT_W-1:0] beat_q;
  logic              valid_q;
  logic              fire;

  assign fire = valid_q & ready;

  always_ff @(posedge clk) begin
    if (!rst) begin
      word_q  <= '0;
      beat_q  <= '0;
      valid_q <= 1'b0;
    end else if (load) begin
      word_q  <= word;
      beat_q  <= '0;
      valid_q <= 1'b1;
    end else if (fire) begin
      // The current beat always sits in the low lane.
      word_q <= word_q >> OUT_W;
      beat_q <= beat_q + 1'b1;
      if (beat_q == LAST_BEAT) begin
        valid_q <= 1'b0;
      end
    end
  end

  assign data      = word_q[OUT_W-1:0];
  assign valid     = valid_q;
  assign last_beat = (beat_q == LAST_BEAT);
  assign word_done = fire & last_beat;

endmodule

// File: rtl/pattern_fifo_reader.sv
// Pattern FIFO drain: pops DATA_W words, serializes OUT_W beats, counts words and patterns.
// Optional PATTERN_UNDERFLOW_CNT_EN adds a saturating count of empty-FIFO stall cycles.
module pattern_fifo_reader
  import pattern_pkg::*;
#(
  parameter int unsigned DATA_W        = DEF_DATA_W,
  parameter int unsigned OUT_W         = DEF_OUT_W,
  parameter int unsigned WORDS_PER_PAT = DEF_WORDS_PER_PAT,
  parameter int unsigned CNT_W         = DEF_CNT_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [CNT_W-1:0]  num_pat,
  input  logic [DATA_W-1:0] fifo_dout,
  input  logic              fifo_empty,
  output logic              fifo_rd_en,
  output logic [OUT_W-1:0]  pat_data,
  output logic              pat_valid,
  input  logic              pat_ready,
  output logic              pat_last,
  output logic              frame_done,
`ifdef PATTERN_UNDERFLOW_CNT_EN
  output logic [15:0]       underflow_cnt,
`endif
  output logic              busy
);

  localparam logic [CNT_W-1:0] LAST_WORD = CNT_W'(WORDS_PER_PAT - 1);

  state_t           state;
  logic [CNT_W-1:0] num_pat_q;
  logic [CNT_W-1:0] pat_cnt;
  logic [CNT_W-1:0] word_cnt;
  logic             start_ok;
  logic             ser_last_beat;
  logic             word_done;

  assign start_ok = (state == S_IDLE) && start && (num_pat != '0);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= S_IDLE;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      num_pat_q  <= '0;
      pat_cnt    <= '0;
      word_cnt   <= '0;
    end else begin
      frame_done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start_ok) begin
            num_pat_q <= num_pat;
            busy      <= 1'b1;
            pat_cnt   <= '0;
            word_cnt  <= '0;
            state     <= S_FETCH;
          end else if (start) begin
            frame_done <= 1'b1;
          end
        end
        S_FETCH: begin
          if (!fifo_empty) begin
            state <= S_WAIT;
          end
        end
        S_WAIT: begin
          state <= S_SHIFT;
        end
        S_SHIFT: begin
          if (word_done) begin
            if (word_cnt < LAST_WORD) begin
              word_cnt <= word_cnt + 1'b1;
              state    <= S_FETCH;
            end else begin
              word_cnt <= '0;
              pat_cnt  <= pat_cnt + 1'b1;
              if (pat_cnt == num_pat_q - 1'b1) begin
                // Raise frame_done on entry so it lands the cycle after the final handshake.
                frame_done <= 1'b1;
                busy       <= 1'b0;
                state      <= S_DONE;
              end else begin
                state <= S_FETCH;
              end
            end
          end
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  // Pop in the same cycle the non-empty FIFO is seen, so data arrives during S_WAIT.
  assign fifo_rd_en = (state == S_FETCH) && !fifo_empty;

  pattern_word_ser #(
    .DATA_W(DATA_W),
    .OUT_W (OUT_W)
  ) u_ser (
    .clk      (clk),
    .rst      (rst),
    .load     (state == S_WAIT),
    .word     (fifo_dout),
    .ready    (pat_ready),
    .data     (pat_data),
    .valid    (pat_valid),
    .last_beat(ser_last_beat),
    .word_done(word_done)
  );

  assign pat_last = pat_valid && ser_last_beat && (word_cnt == LAST_WORD);

`ifdef PATTERN_UNDERFLOW_CNT_EN
  always_ff @(posedge clk) begin
    if (!rst) begin
      underflow_cnt <= '0;
    end else if (start_ok) begin
      underflow_cnt <= '0;
    end else if ((state == S_FETCH) && fifo_empty && busy && (underflow_cnt != 16'hFFFF)) begin
      underflow_cnt <= underflow_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pattern_fifo_reader.sv
// Scoreboard bench for pattern_fifo_reader with a small registered FIFO model.
module tb_pattern_fifo_reader;

  localparam int unsigned DATA_W = 256;
  localparam int unsigned OUT_W  = 32;
  localparam int unsigned WPP    = 4;
  localparam int unsigned CNT_W  = 32;
  localparam int unsigned NBEATS = DATA_W / OUT_W;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              start = 1'b0;
  logic [CNT_W-1:0]  num_pat = '0;
  logic [DATA_W-1:0] fifo_dout = '0;
  logic              fifo_empty;
  logic              fifo_rd_en;
  logic [OUT_W-1:0]  pat_data;
  logic              pat_valid;
  logic              pat_ready = 1'b1;
  logic              pat_last;
  logic              frame_done;
  logic              busy;
`ifdef PATTERN_UNDERFLOW_CNT_EN
  logic [15:0]       underflow_cnt;
`endif

  pattern_fifo_reader #(
    .DATA_W       (DATA_W),
    .OUT_W        (OUT_W),
    .WORDS_PER_PAT(WPP),
    .CNT_W        (CNT_W)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .num_pat      (num_pat),
    .fifo_dout    (fifo_dout),
    .fifo_empty   (fifo_empty),
    .fifo_rd_en   (fifo_rd_en),
    .pat_data     (pat_data),
    .pat_valid    (pat_valid),
    .pat_ready    (pat_ready),
    .pat_last     (pat_last),
    .frame_done   (frame_done),
`ifdef PATTERN_UNDERFLOW_CNT_EN
    .underflow_cnt(underflow_cnt),
`endif
    .busy         (busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [OUT_W-1:0] data;
    logic             last;
  } beat_t;

  beat_t exp_q[$];
  int    n_checks = 0;
  int    n_errors = 0;
  int    cycle = 0;
  logic  bp_mode = 1'b0;

  // FIFO model: registered read data, empty derived from the pointers.
  logic [DATA_W-1:0] fifo_mem [16];
  int                wp = 0;
  int                rp = 0;
  logic              push_req = 1'b0;
  logic              fifo_clr = 1'b0;
  logic [DATA_W-1:0] push_data = '0;

  assign fifo_empty = (wp == rp);

  always @(posedge clk) begin
    cycle <= cycle + 1;
    if (fifo_clr) begin
      wp <= 0;
      rp <= 0;
    end else begin
      if (fifo_rd_en) begin
        fifo_dout <= fifo_mem[rp[3:0]];
        rp <= rp + 1;
      end
      if (push_req) begin
        fifo_mem[wp[3:0]] <= push_data;
        wp <= wp + 1;
      end
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Monitor statistics
  int          beats_seen = 0;
  int          last_seen = 0;
  int          rd_pulses = 0;
  int          done_pulses = 0;
  int          first_valid_cycle = -1;
  int          last_hs_cycle = 0;
  int          done_cycle = 0;
  logic        hold_pending = 1'b0;
  logic [31:0] held_data = '0;
  logic        held_last = 1'b0;

  always @(negedge clk) begin
    if (rst) begin
      if (fifo_rd_en) begin
        rd_pulses++;
        check("rd_en_while_empty", 64'(fifo_empty), 64'd0);
      end
      if (frame_done) begin
        done_pulses++;
        done_cycle = cycle;
      end
      if (pat_valid && first_valid_cycle < 0) first_valid_cycle = cycle;
      if (hold_pending) begin
        check("hold_valid", 64'(pat_valid), 64'd1);
        check("hold_data", 64'(pat_data), 64'(held_data));
        check("hold_last", 64'(pat_last), 64'(held_last));
      end
      if (pat_valid && pat_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_beat", 64'(pat_data), 64'hDEAD_BEEF_0000_0000);
        end else begin
          beat_t e;
          e = exp_q.pop_front();
          check("beat_data", 64'(pat_data), 64'(e.data));
          check("beat_last", 64'(pat_last), 64'(e.last));
        end
        beats_seen++;
        if (pat_last) last_seen++;
        last_hs_cycle = cycle;
      end
      hold_pending = pat_valid && !pat_ready;
      held_data    = pat_data;
      held_last    = pat_last;
    end else begin
      hold_pending = 1'b0;
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (bp_mode) pat_ready = ~pat_ready;
      else pat_ready = 1'b1;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_stats();
    beats_seen = 0;
    last_seen = 0;
    rd_pulses = 0;
    done_pulses = 0;
    first_valid_cycle = -1;
  endtask

  // Lanes carry {word id, lane index} so lane order is visible in the data.
  task automatic push_word(input int k, input int widx);
    beat_t b;
    for (int i = 0; i < int'(NBEATS); i++) begin
      push_data[i*OUT_W +: OUT_W] = {16'(k), 16'(i)};
      b.data = {16'(k), 16'(i)};
      b.last = ((widx % int'(WPP)) == int'(WPP) - 1) && (i == int'(NBEATS) - 1);
      exp_q.push_back(b);
    end
    push_req = 1'b1;
    tick();
    push_req = 1'b0;
  endtask

  int start_cycle = 0;

  task automatic start_frame(input int n);
    num_pat = CNT_W'(n);
    start = 1'b1;
    start_cycle = cycle;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_frame(input int budget);
    int n = 0;
    int base = done_pulses;
    while (done_pulses == base && n < budget) begin
      tick();
      n++;
    end
    check("frame_timeout", 64'(done_pulses != base), 64'd1);
  endtask

  task automatic wait_beats(input int target, input int budget);
    int n = 0;
    while (beats_seen < target && n < budget) begin
      tick();
      n++;
    end
    check("beat_wait_timeout", 64'(beats_seen >= target), 64'd1);
  endtask

  task automatic frame_checks(input string name, input int words, input int pats);
    check({name, "_beats"}, 64'(beats_seen), 64'(words * int'(NBEATS)));
    check({name, "_rd_pulses"}, 64'(rd_pulses), 64'(words));
    check({name, "_last_count"}, 64'(last_seen), 64'(pats));
    check({name, "_done_latency"}, 64'(done_cycle - last_hs_cycle), 64'd1);
    check({name, "_done_count"}, 64'(done_pulses), 64'd1);
    check({name, "_sb_empty"}, 64'(exp_q.size()), 64'd0);
    check({name, "_busy_clear"}, 64'(busy), 64'd0);
  endtask

  initial begin
    int push_cycle;

    // Reset state
    repeat (3) tick();
    check("rst_rd_en", 64'(fifo_rd_en), 64'd0);
    check("rst_valid", 64'(pat_valid), 64'd0);
    check("rst_data", 64'(pat_data), 64'd0);
    check("rst_last", 64'(pat_last), 64'd0);
    check("rst_done", 64'(frame_done), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
`ifdef PATTERN_UNDERFLOW_CNT_EN
    check("rst_underflow", 64'(underflow_cnt), 64'd0);
`endif
    rst = 1'b1;
    tick();

    // Basic frame: 2 patterns of 4 words, FIFO preloaded
    clear_stats();
    for (int k = 0; k < 8; k++) push_word(k, k);
    start_frame(2);
    check("basic_busy_set", 64'(busy), 64'd1);
    wait_frame(1000);
    check("basic_first_beat_latency", 64'(first_valid_cycle - start_cycle), 64'd3);
    frame_checks("basic", 8, 2);
`ifdef PATTERN_UNDERFLOW_CNT_EN
    check("basic_underflow", 64'(underflow_cnt), 64'd0);
`endif

    // Backpressure: pat_ready toggles every cycle
    tick();
    clear_stats();
    for (int k = 0; k < 8; k++) push_word(16 + k, k);
    bp_mode = 1'b1;
    start_frame(2);
    wait_frame(2000);
    frame_checks("bp", 8, 2);
    bp_mode = 1'b0;

    // Empty stall: 20 empty cycles in S_FETCH, then words arrive
    repeat (2) tick();
    clear_stats();
    start_frame(1);
    repeat (19) tick();
    check("stall_no_rd_en", 64'(rd_pulses), 64'd0);
    check("stall_no_valid", 64'(pat_valid), 64'd0);
    push_cycle = cycle;
    for (int k = 0; k < 4; k++) push_word(32 + k, k);
    wait_frame(1000);
    check("stall_first_beat_latency", 64'(first_valid_cycle - push_cycle), 64'd3);
    frame_checks("stall", 4, 1);
`ifdef PATTERN_UNDERFLOW_CNT_EN
    check("stall_underflow", 64'(underflow_cnt), 64'd20);
`endif

    // Zero patterns
    tick();
    clear_stats();
    start_frame(0);
    check("zero_done_pulse", 64'(frame_done), 64'd1);
    check("zero_busy", 64'(busy), 64'd0);
    tick();
    check("zero_done_single", 64'(frame_done), 64'd0);
    repeat (5) tick();
    check("zero_no_rd_en", 64'(rd_pulses), 64'd0);
    check("zero_no_valid", 64'(pat_valid), 64'd0);

    // Mid-frame reset during beat 5 of word 1
    clear_stats();
    for (int k = 0; k < 8; k++) push_word(48 + k, k);
    start_frame(2);
    wait_beats(NBEATS + 5, 500);
    rst = 1'b0;
    tick();
    check("midrst_valid", 64'(pat_valid), 64'd0);
    check("midrst_data", 64'(pat_data), 64'd0);
    check("midrst_last", 64'(pat_last), 64'd0);
    check("midrst_busy", 64'(busy), 64'd0);
    check("midrst_rd_en", 64'(fifo_rd_en), 64'd0);
    check("midrst_done", 64'(frame_done), 64'd0);
    exp_q.delete();
    fifo_clr = 1'b1;
    tick();
    fifo_clr = 1'b0;
    rst = 1'b1;
    tick();
    clear_stats();
    for (int k = 0; k < 4; k++) push_word(64 + k, k);
    start_frame(1);
    wait_frame(1000);
    frame_checks("after_rst", 4, 1);

    // Start while busy, with num_pat changed to 7
    tick();
    clear_stats();
    for (int k = 0; k < 8; k++) push_word(80 + k, k);
    start_frame(2);
    wait_beats(3, 500);
    num_pat = CNT_W'(7);
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_frame(1000);
    frame_checks("busy_start", 8, 2);
    repeat (20) tick();
    check("busy_start_idle", 64'(busy), 64'd0);
    check("busy_start_rd_total", 64'(rd_pulses), 64'd8);
    check("busy_start_done_total", 64'(done_pulses), 64'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not reach the end");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/pattern_fifo_reader.md
Name: pattern_fifo_reader

Overview:
- Drain side of the pattern FIFO: pops 256-bit pattern words and serializes them into 32-bit beats for the imager's mask-load interface.
- Counts WORDS_PER_PAT words per pattern and num_pat patterns per frame.
- Flags the last beat of each pattern and pulses frame_done at the end of the frame.

Parameters:
- DATA_W, 256, FIFO word width.
- OUT_W, 32, imager beat width; DATA_W must be an integer multiple of OUT_W.
- WORDS_PER_PAT, 640, FIFO words per pattern (matches the loader's stream count).
- CNT_W, 32, width of the pattern and word counters.

Ports:
- clk  in  1  single clock; all state updates on its rising edge.
- rst  in  1  synchronous, active-low reset.
- start  in  1  one-cycle frame start request.
- num_pat  in  CNT_W  patterns per frame; latched on an accepted start.
- fifo_dout  in  DATA_W  pattern FIFO read data, valid the cycle after fifo_rd_en.
- fifo_empty  in  1  pattern FIFO empty.
- fifo_rd_en  out  1  pattern FIFO pop, one-cycle pulse.
- pat_data  out  OUT_W  beat to the imager.
- pat_valid  out  1  pat_data valid.
- pat_ready  in  1  imager accepts the beat.
- pat_last  out  1  qualifies the final beat of a pattern.
- frame_done  out  1  one-cycle pulse at frame end.
- busy  out  1  high from accepted start until frame_done.

Behaviour:
- Reset (rst==0 at a clk edge):
  - state S_IDLE.
  - All outputs 0.
  - Counters and shift register cleared.
  - Reset asserted mid-frame aborts immediately. The FIFO is not flushed; that is the owner's job.
- S_IDLE:
  - start==1 and num_pat!=0: latch num_pat, busy<=1, pat_cnt=0, word_cnt=0, go to S_FETCH.
  - start==1 and num_pat==0: frame_done pulses the next cycle, stay in S_IDLE, busy stays 0.
  - start while busy is ignored. num_pat changes mid-frame are ignored.
- S_FETCH:
  - fifo_empty==0: fifo_rd_en<=1 for exactly one cycle, go to S_WAIT.
  - Otherwise stall indefinitely. No timeout, pat_valid=0.
- S_WAIT: capture fifo_dout into the shift register, beat=0, go to S_SHIFT.
- S_SHIFT:
  - pat_valid=1; pat_data = word[beat*OUT_W +: OUT_W], LSB lane first.
  - pat_valid, pat_data and pat_last hold stable until pat_valid&&pat_ready.
  - On each handshake, beat++.
  - On the handshake of beat DATA_W/OUT_W-1:
    - If word_cnt<WORDS_PER_PAT-1: word_cnt++, go to S_FETCH.
    - Otherwise: word_cnt=0, pat_cnt++, go to S_FETCH if more patterns remain, else S_DONE.
  - pat_last=1 only on the final beat of word WORDS_PER_PAT-1.
- S_DONE: frame_done<=1 for one cycle, busy<=0, go to S_IDLE.
- Latency and throughput:
  - Start-to-first-beat is 3 cycles with a non-empty FIFO.
  - Per-word overhead is 2 bubble cycles (S_FETCH, S_WAIT).
  - A word costs DATA_W/OUT_W+2 cycles with pat_ready held high.
- Arithmetic: counters are unsigned CNT_W. Comparisons use the latched num_pat-1, evaluated only when num_pat!=0.
- fifo_rd_en never asserts while fifo_empty==1 or outside S_FETCH.

Optional Feature:
- Macro: PATTERN_UNDERFLOW_CNT_EN.
- When defined:
  - Adds output underflow_cnt [15:0], counting cycles spent in S_FETCH with fifo_empty==1 while busy.
  - Saturates at 16'hFFFF.
  - Clears on an accepted start and on reset.
- When undefined: the port and counter do not exist; all other behaviour is identical.

Decomposition:
- Package pattern_pkg holds:
  - state encoding (S_IDLE, S_FETCH, S_WAIT, S_SHIFT, S_DONE);
  - default DATA_W, OUT_W, WORDS_PER_PAT;
  - BEATS = DATA_W/OUT_W.
- One sub-module, pattern_word_ser: load strobe, DATA_W word register, beat index, valid/ready stepping, last_beat output.
- Frame and pattern counting stays in the parent.

Test Plan:
- Basic frame (WORDS_PER_PAT=4, num_pat=2, FIFO preloaded with 8 words, word k = {8{32'h0 + k}}, pat_ready=1) -> 64 beats in order; pat_last on beats 31 and 63; frame_done 1 cycle after the final handshake; exactly 8 fifo_rd_en pulses.
- Backpressure (pat_ready toggling 1/0 every cycle) -> pat_data and pat_last stable while pat_ready=0; beat order and count identical to the basic frame.
- Empty stall (FIFO empty for 20 cycles after start, then 1 word pushed) -> no fifo_rd_en during the stall; first beat 3 cycles after fifo_empty falls; underflow_cnt=20 when PATTERN_UNDERFLOW_CNT_EN is defined.
- Zero patterns (start with num_pat=0) -> frame_done pulses the next cycle; busy stays 0; no fifo_rd_en.
- Mid-frame reset (rst=0 during beat 5 of word 1) -> all outputs 0 the next cycle; a new start with num_pat=1 produces a clean 32-beat pattern.
- Start while busy (second start during S_SHIFT, num_pat changed to 7) -> ignored; frame still completes after the original pattern count.
